// File: rtl/acc_frame_tx.sv
// Snapshots the accumulator {value, overflow} on a capture strobe and sends it as a serial frame.
// Also counts overflow rising edges with saturation. Optional parity bit: define ACC_FRAME_TX_PARITY_EN.
module acc_frame_tx #(
    parameter int NB_DATA    = 6,
    parameter int CLK_DIV    = 4,
    parameter int NB_OVF_CNT = 4
) (
    input  logic                  clock,
    input  logic                  i_rst,
    input  logic [NB_DATA-1:0]    i_data,
    input  logic                  i_overflow,
    input  logic                  i_capture,
    input  logic                  i_cnt_clr,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [NB_OVF_CNT-1:0] o_ovf_cnt
);
    localparam int TW = $clog2(CLK_DIV);
    localparam int BW = $clog2(NB_DATA);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        FLAG,
`ifdef ACC_FRAME_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [TW-1:0]       timer;
    logic [BW-1:0]       bit_cnt;
    logic [NB_DATA-1:0]  shift_reg;
    logic                flag_q;
    logic                load;
    logic                done_nxt;
    logic                timer_last;
    logic                bit_last;
    logic                ovf_q;
    logic                ovf_rise;
`ifdef ACC_FRAME_TX_PARITY_EN
    logic                parity_q;
`endif

    assign timer_last = (timer == TW'(CLK_DIV - 1));
    assign bit_last   = (bit_cnt == BW'(NB_DATA - 1));
    assign ovf_rise   = i_overflow & ~ovf_q;

    always_ff @(posedge clock) begin
        if (i_rst) begin
            state     <= IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            flag_q    <= 1'b0;
            o_done    <= 1'b0;
`ifdef ACC_FRAME_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            o_done <= done_nxt;
            if (state == IDLE || timer_last)
                timer <= '0;
            else
                timer <= timer + TW'(1);
            if (load) begin
                shift_reg <= i_data;
                flag_q    <= i_overflow;
                bit_cnt   <= '0;
`ifdef ACC_FRAME_TX_PARITY_EN
                parity_q  <= ^i_data ^ i_overflow;
`endif
            end else if (state == DATA && timer_last) begin
                // LSB goes out first, so shift right at the end of each data bit
                shift_reg <= shift_reg >> 1;
                bit_cnt   <= bit_cnt + BW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        o_tx      = 1'b1;
        o_busy    = 1'b1;
        load      = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_capture) begin
                    load      = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                o_tx = 1'b0;
                if (timer_last) state_nxt = DATA;
            end
            DATA: begin
                o_tx = shift_reg[0];
                if (timer_last && bit_last) state_nxt = FLAG;
            end
            FLAG: begin
                o_tx = flag_q;
`ifdef ACC_FRAME_TX_PARITY_EN
                if (timer_last) state_nxt = PARITY;
`else
                if (timer_last) state_nxt = STOP;
`endif
            end
`ifdef ACC_FRAME_TX_PARITY_EN
            PARITY: begin
                o_tx = parity_q;
                if (timer_last) state_nxt = STOP;
            end
`endif
            STOP: begin
                if (timer_last) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Edge counter is independent of the frame FSM; clear beats a coincident edge
    always_ff @(posedge clock) begin
        if (i_rst) begin
            ovf_q     <= 1'b0;
            o_ovf_cnt <= '0;
        end else begin
            ovf_q <= i_overflow;
            if (i_cnt_clr)
                o_ovf_cnt <= '0;
            else if (ovf_rise && o_ovf_cnt != {NB_OVF_CNT{1'b1}})
                o_ovf_cnt <= o_ovf_cnt + NB_OVF_CNT'(1);
        end
    end
endmodule
